// File: rtl/box_motion_if.sv
// Handshake/bus bundle for box_motion_ctrl.
//   master : drives frame_start, direction buttons and mode; observes position
//   slave  : the controller; receives requests and drives box_x/box_y,
//            pos_valid and busy
interface box_motion_if #(
  parameter int X_W = 12,
  parameter int Y_W = 11
);
  logic           frame_start;
  logic           lft;
  logic           rgt;
  logic           up;
  logic           dn;
  logic           mode;
  logic [X_W-1:0] box_x;
  logic [Y_W-1:0] box_y;
  logic           pos_valid;
  logic           busy;

  modport master (
    output frame_start, lft, rgt, up, dn, mode,
    input  box_x, box_y, pos_valid, busy
  );

  modport slave (
    input  frame_start, lft, rgt, up, dn, mode,
    output box_x, box_y, pos_valid, busy
  );
endinterface

// File: rtl/box_motion_ctrl.sv
// Per-frame box position controller. On each accepted frame_start the
// buttons/mode are sampled, the new x and y are computed and clamped to the
// visible area, and both are committed together with a one-cycle pos_valid.
// Ports:
//   clk  : single rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : box_motion_if.slave (frame_start, lft/rgt/up/dn, mode in;
//          box_x, box_y, pos_valid, busy out)
//
// state  | meaning
// IDLE   | waiting for frame_start
// SAMPLE | capture buttons and mode
// CALC_X | compute and clamp next x
// CALC_Y | compute and clamp next y
// COMMIT | update position, toggle bounce directions on bound hits
module box_motion_ctrl #(
  parameter int H_ACTIVE = 1920,
  parameter int V_ACTIVE = 1080,
  parameter int BOX_SIZE = 350,
  parameter int STEP     = 4,
  parameter int X_W      = 12,
  parameter int Y_W      = 11
) (
  input logic         clk,
  input logic         rst,
  box_motion_if.slave bus
);

  localparam int X_MAX  = H_ACTIVE - BOX_SIZE;
  localparam int Y_MAX  = V_ACTIVE - BOX_SIZE;
  localparam int X_INIT = X_MAX / 2;
  localparam int Y_INIT = Y_MAX / 2;

  // One extra sign bit so a step below zero is seen as negative, not wrapped.
  localparam logic signed [X_W:0] X_MAX_S = (X_W+1)'(X_MAX);
  localparam logic signed [Y_W:0] Y_MAX_S = (Y_W+1)'(Y_MAX);
  localparam logic signed [X_W:0] STEP_XS = (X_W+1)'(STEP);
  localparam logic signed [Y_W:0] STEP_YS = (Y_W+1)'(STEP);

  typedef enum logic [2:0] {IDLE, SAMPLE, CALC_X, CALC_Y, COMMIT} state_t;

  state_t          state;
  logic            lft_s, rgt_s, up_s, dn_s, mode_s;
  logic            dir_x, dir_y;
  logic [X_W-1:0]  box_x_q, calc_x;
  logic [Y_W-1:0]  box_y_q, calc_y;
  logic            hit_x, hit_y;
  logic            pos_valid_q, busy_q;

  logic            x_inc, x_dec, y_inc, y_dec;
  logic signed [X_W:0] x_sum;
  logic signed [Y_W:0] y_sum;

  // Bounce mode follows the direction bits; manual mode needs exactly one
  // button per axis, opposing presses cancel.
  always_comb begin
    x_inc = mode_s ? ~dir_x : (rgt_s & ~lft_s);
    x_dec = mode_s ?  dir_x : (lft_s & ~rgt_s);
    y_inc = mode_s ? ~dir_y : (dn_s & ~up_s);
    y_dec = mode_s ?  dir_y : (up_s & ~dn_s);

    x_sum = $signed({1'b0, box_x_q});
    if (x_inc)      x_sum = x_sum + STEP_XS;
    else if (x_dec) x_sum = x_sum - STEP_XS;

    y_sum = $signed({1'b0, box_y_q});
    if (y_inc)      y_sum = y_sum + STEP_YS;
    else if (y_dec) y_sum = y_sum - STEP_YS;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      box_x_q     <= X_W'(X_INIT);
      box_y_q     <= Y_W'(Y_INIT);
      dir_x       <= 1'b0;
      dir_y       <= 1'b0;
      lft_s       <= 1'b0;
      rgt_s       <= 1'b0;
      up_s        <= 1'b0;
      dn_s        <= 1'b0;
      mode_s      <= 1'b0;
      calc_x      <= '0;
      calc_y      <= '0;
      hit_x       <= 1'b0;
      hit_y       <= 1'b0;
      pos_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      pos_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.frame_start) begin
            state  <= SAMPLE;
            busy_q <= 1'b1;
          end
        end
        SAMPLE: begin
          lft_s  <= bus.lft;
          rgt_s  <= bus.rgt;
          up_s   <= bus.up;
          dn_s   <= bus.dn;
          mode_s <= bus.mode;
          state  <= CALC_X;
        end
        CALC_X: begin
          if (x_sum < 0) begin
            calc_x <= '0;
            hit_x  <= 1'b1;
          end else if (x_sum > X_MAX_S) begin
            calc_x <= X_W'(X_MAX);
            hit_x  <= 1'b1;
          end else begin
            calc_x <= x_sum[X_W-1:0];
            hit_x  <= 1'b0;
          end
          state <= CALC_Y;
        end
        CALC_Y: begin
          if (y_sum < 0) begin
            calc_y <= '0;
            hit_y  <= 1'b1;
          end else if (y_sum > Y_MAX_S) begin
            calc_y <= Y_W'(Y_MAX);
            hit_y  <= 1'b1;
          end else begin
            calc_y <= y_sum[Y_W-1:0];
            hit_y  <= 1'b0;
          end
          state <= COMMIT;
        end
        COMMIT: begin
          box_x_q     <= calc_x;
          box_y_q     <= calc_y;
          // Direction bits only flip in bounce mode; manual mode holds them.
          if (mode_s && hit_x) dir_x <= ~dir_x;
          if (mode_s && hit_y) dir_y <= ~dir_y;
          pos_valid_q <= 1'b1;
          busy_q      <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.box_x     = box_x_q;
  assign bus.box_y     = box_y_q;
  assign bus.pos_valid = pos_valid_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_box_motion_ctrl.sv
module tb_box_motion_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  longint cyc = 0;

  box_motion_if #(.X_W(12), .Y_W(11)) bus ();

  box_motion_ctrl #(
    .H_ACTIVE(1920), .V_ACTIVE(1080), .BOX_SIZE(350), .STEP(4), .X_W(12), .Y_W(11)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     x;
    int     y;
    longint at;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done = 0;

  // reference model state
  int mx, my;
  bit mdx, mdy;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mx = 785; my = 365; mdx = 0; mdy = 0;
  endtask

  task automatic model_step(input bit l, input bit r, input bit u, input bit d, input bit m);
    int nx, ny;
    nx = mx; ny = my;
    if (m) begin
      nx = mdx ? mx - 4 : mx + 4;
      ny = mdy ? my - 4 : my + 4;
    end else begin
      if (r && !l) nx = mx + 4; else if (l && !r) nx = mx - 4;
      if (d && !u) ny = my + 4; else if (u && !d) ny = my - 4;
    end
    if (nx < 0)         begin nx = 0;    if (m) mdx = !mdx; end
    else if (nx > 1570) begin nx = 1570; if (m) mdx = !mdx; end
    if (ny < 0)         begin ny = 0;    if (m) mdy = !mdy; end
    else if (ny > 730)  begin ny = 730;  if (m) mdy = !mdy; end
    mx = nx; my = ny;
  endtask

  // One frame; inputs are inverted right after SAMPLE to show they are ignored.
  // extra_fs adds a second frame_start pulse two cycles after the first.
  task automatic frame(input bit l, input bit r, input bit u, input bit d, input bit m,
                       input bit extra_fs);
    @(negedge clk);
    model_step(l, r, u, d, m);
    q.push_back('{mx, my, cyc + 5});
    bus.lft = l; bus.rgt = r; bus.up = u; bus.dn = d; bus.mode = m;
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
    chk("busy_in_sample", bus.busy, 1);
    @(negedge clk);
    bus.lft = ~l; bus.rgt = ~r; bus.up = ~u; bus.dn = ~d; bus.mode = ~m;
    if (extra_fs) bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_back_idle", bus.busy, 0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!done && bus.pos_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pos_valid: got pulse at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("box_x", bus.box_x, e.x);
        chk("box_y", bus.box_y, e.y);
        chk("pos_valid_latency", cyc, e.at);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    bus.frame_start = 0; bus.lft = 0; bus.rgt = 0; bus.up = 0; bus.dn = 0; bus.mode = 0;
    model_reset();

    // Reset with a simultaneous frame_start: reset wins
    repeat (3) @(negedge clk);
    bus.frame_start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.frame_start = 1'b0;
    chk("reset_busy", bus.busy, 0);
    chk("reset_pos_valid", bus.pos_valid, 0);
    chk("reset_x", bus.box_x, 785);
    chk("reset_y", bus.box_y, 365);
    @(negedge clk);
    chk("fs_during_reset_ignored", bus.busy, 0);

    // Manual single-axis moves
    frame(0, 1, 0, 0, 0, 0);
    chk("rgt_x", bus.box_x, 789);
    chk("rgt_y", bus.box_y, 365);
    frame(0, 0, 1, 0, 0, 0);
    chk("up_y", bus.box_y, 361);
    frame(0, 0, 0, 1, 0, 0);
    chk("dn_y", bus.box_y, 365);
    frame(1, 1, 1, 1, 0, 0);
    chk("all_btn_x", bus.box_x, 789);
    chk("all_btn_y", bus.box_y, 365);

    // Drive to the right bound, then one more push into it
    guard = 0;
    while (mx != 1570 && guard < 300) begin frame(0, 1, 0, 0, 0, 0); guard++; end
    chk("reach_xmax_guard", guard < 300, 1);
    chk("xmax", bus.box_x, 1570);
    frame(0, 1, 0, 0, 0, 0);
    chk("xmax_hold", bus.box_x, 1570);

    // Down to x=2, then underflow clamps to 0 twice
    guard = 0;
    while (mx != 2 && guard < 500) begin frame(1, 0, 0, 0, 0, 0); guard++; end
    chk("reach_x2_guard", guard < 500, 1);
    chk("x_is_2", bus.box_x, 2);
    frame(1, 0, 0, 0, 0, 0);
    chk("x_clamp_0", bus.box_x, 0);
    frame(1, 0, 0, 0, 0, 0);
    chk("x_hold_0", bus.box_x, 0);

    // Bounce up to 1568, then hit the bound and reverse
    guard = 0;
    while (mx != 1568 && guard < 500) begin frame(0, 0, 0, 0, 1, 0); guard++; end
    chk("reach_1568_guard", guard < 500, 1);
    chk("bounce_1568", bus.box_x, 1568);
    frame(1, 1, 0, 0, 1, 0);
    chk("bounce_hit_xmax", bus.box_x, 1570);
    frame(0, 0, 0, 0, 1, 0);
    chk("bounce_reverse", bus.box_x, 1566);
    frame(0, 0, 0, 0, 0, 0);
    chk("manual_hold", bus.box_x, 1566);
    frame(0, 0, 0, 0, 1, 0);
    chk("bounce_resume", bus.box_x, 1562);

    // Second frame_start while busy is dropped
    frame(0, 1, 0, 0, 0, 1);
    chk("double_fs_x", bus.box_x, 1566);
    repeat (3) @(negedge clk);
    chk("double_fs_idle", bus.busy, 0);

    // Reset during CALC_Y aborts the update
    @(negedge clk);
    bus.rgt = 1'b1; bus.lft = 1'b0; bus.mode = 1'b0;
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("abort_x", bus.box_x, 785);
    chk("abort_y", bus.box_y, 365);
    chk("abort_busy", bus.busy, 0);
    chk("abort_pos_valid", bus.pos_valid, 0);
    repeat (4) @(negedge clk);

    // First frame after reset is accepted
    frame(0, 1, 0, 0, 0, 0);
    chk("post_reset_x", bus.box_x, 789);

    repeat (10) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    done = 1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
